// File: rtl/decoder_pkg.sv
// Shared types and decode helper for the valid/ready one-hot decoder.
// Holds the output-buffer state enum and the index-to-one-hot function.
// No ports; imported by decoder_skid_buf and decoder_stream.
package decoder_pkg;

    // Widest one-hot output the decode helper supports; decoder_stream keeps N <= MAX_N.
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } state_e;

    // Returns {err, op}. err is bit MAX_N and op sits in bits [n-1:0].
    // An out-of-range index always flags err and yields op=0, whatever en says.
    function automatic logic [MAX_N:0] onehot_dec(input logic [31:0] idx,
                                                   input logic        en,
                                                   input int unsigned n);
        logic [MAX_N:0] res;
        res = '0;
        if (idx >= n) begin
            res[MAX_N] = 1'b1;
        end else if (en) begin
            for (int i = 0; i < MAX_N; i++) begin
                if (idx == 32'(i)) begin
                    res[i] = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid register.
// Latency 1 cycle (accept at edge k -> out_vld after edge k); full throughput.
// Backpressure: in_rdy is registered and drops only when both entries are held.
// Ports: clk, rst (sync, active-high); in_vld/in_rdy/in_dat upstream;
//        out_vld/out_rdy/out_dat downstream. out_dat is all-zero when empty.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             rdy_q, rdy_d;
    logic             accept;
    logic             deliver;

    assign out_vld = (state_q != EMPTY);
    assign out_dat = out_dat_q;
    // Gate with rst so upstream never sees ready during reset, even mid-transfer.
    assign in_rdy  = rdy_q & ~rst;

    always_comb begin
        state_d    = state_q;
        out_dat_d  = out_dat_q;
        skid_dat_d = skid_dat_q;
        accept     = in_vld & rdy_q;
        deliver    = out_vld & out_rdy;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_dat_d = in_dat;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    skid_dat_d = in_dat;
                    state_d    = FULL2;
                end else if (accept && deliver) begin
                    out_dat_d = in_dat;
                end else if (deliver) begin
                    // Clear on drain so the output reads zero while empty.
                    out_dat_d = '0;
                    state_d   = EMPTY;
                end
            end
            FULL2: begin
                if (deliver) begin
                    out_dat_d  = skid_dat_q;
                    skid_dat_d = '0;
                    state_d    = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Ready for next cycle is decided from the next state, keeping it a flop output.
        rdy_d = (state_d != FULL2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_dat_q  <= '0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_dat_q  <= out_dat_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= rdy_d;
        end
    end

endmodule

// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot decoder with enable gating and range check.
// Latency 1 cycle; SKID=1 sustains 1/cycle with registered in_ready.
// Backpressure: SKID=1 holds two items; SKID=0 holds one, in_ready = !out_valid | out_ready.
// Ports: clk, rst (sync, active-high), en, in_valid/in_ready/a (index),
//        out_valid/out_ready, op (one-hot, N bits), err (index >= N).
module decoder_stream
    import decoder_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int SKID    = 1,
    localparam int IN_SIZE = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_SIZE-1:0] a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       op,
    output logic               err
);

    logic [MAX_N:0] dec_res;
    logic [N:0]     dec_dat;
    logic           dec_unused;

    // Decode is purely combinational on the incoming index; the result is
    // captured only when the index is accepted.
    always_comb begin
        dec_res = onehot_dec(32'(a), en, N);
        dec_dat = {dec_res[MAX_N], dec_res[N-1:0]};
    end

    // Upper helper bits beyond N are always zero here.
    assign dec_unused = ^dec_res;

    if (SKID != 0) begin : g_skid
        logic [N:0] buf_dat;

        decoder_skid_buf #(
            .WIDTH(N + 1)
        ) u_skid (
            .clk    (clk),
            .rst    (rst),
            .in_vld (in_valid),
            .in_rdy (in_ready),
            .in_dat (dec_dat),
            .out_vld(out_valid),
            .out_rdy(out_ready),
            .out_dat(buf_dat)
        );

        assign op  = buf_dat[N-1:0];
        assign err = buf_dat[N];
    end else begin : g_noskid
        logic       vld_q, vld_d;
        logic [N:0] dat_q, dat_d;
        logic       accept;
        logic       deliver;

        // Combinational ready: a taken output slot can be refilled the same edge.
        assign in_ready = (~vld_q | out_ready) & ~rst;

        always_comb begin
            vld_d   = vld_q;
            dat_d   = dat_q;
            accept  = in_valid & in_ready;
            deliver = vld_q & out_ready;
            if (accept) begin
                vld_d = 1'b1;
                dat_d = dec_dat;
            end else if (deliver) begin
                vld_d = 1'b0;
                dat_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign out_valid = vld_q;
        assign op        = dat_q[N-1:0];
        assign err       = dat_q[N];
    end

endmodule
